// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters and the fixed/rotating priority arbiter.
interface prio_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    modport master (output req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/prio_arbiter.sv
// Registered 4-way arbiter with ownership hold and optional MAX_HOLD preemption.
// Define PRIO_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed 3>2>1>0.
module prio_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_arbiter_if.slave bus
);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [3:0] masked;
    logic [1:0] win_req;
    logic [1:0] win_msk;
    logic       new_grant;
    logic [1:0] new_idx;

    assign masked = bus.req & ~gnt_q;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;

    // Search starts just below the last owner and wraps, so the last owner is tried last.
    function automatic logic [1:0] win(input logic [3:0] c, input logic [1:0] last);
        logic [1:0] k;
        win = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            k = last - 2'(i);
            if (c[k]) win = k;
        end
    endfunction

    assign win_req = win(bus.req, last_q);
    assign win_msk = win(masked, last_q);
`else
    function automatic logic [1:0] win(input logic [3:0] c);
        win = 2'd0;
        priority case (1'b1)
            c[3]:    win = 2'd3;
            c[2]:    win = 2'd2;
            c[1]:    win = 2'd1;
            default: win = 2'd0;
        endcase
    endfunction

    assign win_req = win(bus.req);
    assign win_msk = win(masked);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        new_grant = 1'b0;
        new_idx   = idx_q;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    new_grant = 1'b1;
                    new_idx   = win_req;
                end
            end
            BUSY: begin
                if (bus.req[idx_q]) begin
                    if (MAX_HOLD == 0 || hold_q < HOLD_MAX) begin
                        if (hold_q != '1) hold_d = hold_q + HOLD_ONE;
                    end else if (|masked) begin
                        new_grant = 1'b1;
                        new_idx   = win_msk;
                    end else begin
                        hold_d = HOLD_ONE;
                    end
                end else if (|bus.req) begin
                    new_grant = 1'b1;
                    new_idx   = win_req;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'd0;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d = BUSY;
            gnt_d   = 4'b0001 << new_idx;
            idx_d   = new_idx;
            hold_d  = HOLD_ONE;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            last_d  = new_idx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            hold_q  <= '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            last_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
endmodule
